// File: rtl/game_pkg.sv
// Shared game definitions: game FSM state encoding, playfield geometry and the
// running/home classification used by blocks that react to the game state.
package game_pkg;

   localparam logic [3:0] TITLE    = 4'd0;
   localparam logic [3:0] TITLE1   = 4'd1;
   localparam logic [3:0] TITLE2   = 4'd2;
   localparam logic [3:0] TITLE3   = 4'd3;
   localparam logic [3:0] TITLE4   = 4'd4;
   localparam logic [3:0] RUN1     = 4'd5;
   localparam logic [3:0] RUN2     = 4'd6;
   localparam logic [3:0] JUMP1    = 4'd7;
   localparam logic [3:0] JUMP2    = 4'd8;
   localparam logic [3:0] DUCK1    = 4'd9;
   localparam logic [3:0] DUCK2    = 4'd10;
   localparam logic [3:0] IDLE     = 4'd11;
   localparam logic [3:0] CHARSEL0 = 4'd12;
   localparam logic [3:0] CHARSEL1 = 4'd13;
   localparam logic [3:0] FAIL1    = 4'd14;
   localparam logic [3:0] FAIL2    = 4'd15;

   localparam logic [9:0] H_MIN  = 10'd170;
   localparam logic [9:0] H_MAX  = 10'd750;
   localparam logic [9:0] V_MIN  = 10'd34;
   localparam logic [9:0] V_MAX  = 10'd516;
   localparam logic [9:0] H_LAST = 10'd799;
   localparam logic [9:0] V_LAST = 10'd524;

   // Collision detector's own supervision states, distinct from game states.
   typedef enum logic [1:0] {
      DET_IDLE,
      DET_GRACE,
      DET_ARMED,
      DET_HIT
   } det_state_t;

   function automatic logic is_running(input logic [3:0] s);
      return (s >= RUN1) && (s <= DUCK2);
   endfunction

   function automatic logic is_home(input logic [3:0] s);
      return (s <= TITLE4) || ((s >= IDLE) && (s <= CHARSEL1));
   endfunction

endpackage

// File: rtl/collision_detector_overlap_counter.sv
// Counts strobed pixels where player and obstacle overlap inside the playfield,
// and snapshots/clears that count at every frame end.
module overlap_counter
   import game_pkg::*;
#(
   parameter int         CNTW  = 12,
   parameter logic [9:0] X_MIN = H_MIN,
   parameter logic [9:0] X_MAX = H_MAX,
   parameter logic [9:0] Y_MIN = V_MIN,
   parameter logic [9:0] Y_MAX = V_MAX,
   parameter logic [9:0] X_END = H_LAST,
   parameter logic [9:0] Y_END = V_LAST
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            pix_stb,
   input  logic [9:0]      hc,
   input  logic [9:0]      vc,
   input  logic [3:0]      player_pix,
   input  logic [3:0]      obstacle_pix,
   output logic            frame_end,
   output logic [CNTW-1:0] ovl_cnt,
   output logic            frame_tick,
   output logic [CNTW-1:0] last_overlap
);

   localparam logic [CNTW-1:0] CNT_MAX = '1;

   logic in_window;
   logic overlap;

   assign in_window = (hc >= X_MIN) && (hc <= X_MAX) && (vc >= Y_MIN) && (vc <= Y_MAX);
   assign overlap   = pix_stb && in_window && (|player_pix) && (|obstacle_pix);
   assign frame_end = pix_stb && (hc == X_END) && (vc == Y_END);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ovl_cnt      <= '0;
         last_overlap <= '0;
         frame_tick   <= 1'b0;
      end else begin
         frame_tick <= frame_end;
         if (frame_end) begin
            last_overlap <= ovl_cnt;
            ovl_cnt      <= '0;
         end else if (overlap && (ovl_cnt != CNT_MAX)) begin
            ovl_cnt <= ovl_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/collision_detector.sv
// Debounces per-frame sprite/obstacle overlap into a latched collision for the
// game FSM, ignoring the first frames after play starts.
module collision_detector
   import game_pkg::*;
#(
   parameter int HIT_THRESH   = 8,
   parameter int CONSEC       = 2,
   parameter int GRACE_FRAMES = 30,
   parameter int CNTW         = 12
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            pix_stb,
   input  logic [9:0]      hc,
   input  logic [9:0]      vc,
   input  logic [3:0]      state,
   input  logic [3:0]      player_pix,
   input  logic [3:0]      obstacle_pix,
   output logic            hit_pulse,
   output logic            fail_latched,
   output logic [CNTW-1:0] last_overlap,
   output logic            frame_tick
);

   localparam int GW = $clog2(GRACE_FRAMES + 1);
   localparam int CW = $clog2(CONSEC + 1);

   localparam logic [GW-1:0] GRACE_LAST  = GW'(GRACE_FRAMES);
   localparam logic [CW-1:0] CONSEC_LAST = CW'(CONSEC);
   localparam logic [31:0]   THRESH      = 32'(HIT_THRESH);

   logic            frame_end;
   logic [CNTW-1:0] ovl_cnt;
   logic            running;
   logic            home;
   logic            colliding;
   logic [GW-1:0]   grace_nxt;
   logic [CW-1:0]   consec_nxt;

   det_state_t      det_state;
   logic [GW-1:0]   grace_cnt;
   logic [CW-1:0]   consec_cnt;

   overlap_counter #(
      .CNTW (CNTW)
   ) u_overlap (
      .CLK          (CLK),
      .RESET        (RESET),
      .pix_stb      (pix_stb),
      .hc           (hc),
      .vc           (vc),
      .player_pix   (player_pix),
      .obstacle_pix (obstacle_pix),
      .frame_end    (frame_end),
      .ovl_cnt      (ovl_cnt),
      .frame_tick   (frame_tick),
      .last_overlap (last_overlap)
   );

   assign running    = is_running(state);
   assign home       = is_home(state);
   assign colliding  = 32'(ovl_cnt) >= THRESH;
   assign grace_nxt  = grace_cnt + 1'b1;
   assign consec_nxt = consec_cnt + 1'b1;

   // Home is checked before any frame-end evaluation, so returning to a menu
   // on the last pixel of a frame can never declare a hit.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         det_state    <= DET_IDLE;
         grace_cnt    <= '0;
         consec_cnt   <= '0;
         hit_pulse    <= 1'b0;
         fail_latched <= 1'b0;
      end else begin
         hit_pulse <= 1'b0;
         case (det_state)
            DET_IDLE: begin
               if (running) begin
                  det_state <= DET_GRACE;
                  grace_cnt <= '0;
               end
            end

            DET_GRACE: begin
               if (home) begin
                  det_state <= DET_IDLE;
               end else if (frame_end) begin
                  grace_cnt <= grace_nxt;
                  if (grace_nxt == GRACE_LAST) begin
                     det_state  <= DET_ARMED;
                     consec_cnt <= '0;
                  end
               end
            end

            DET_ARMED: begin
               if (home) begin
                  det_state  <= DET_IDLE;
                  consec_cnt <= '0;
               end else if (frame_end && running) begin
                  if (colliding) begin
                     consec_cnt <= consec_nxt;
                     if (consec_nxt == CONSEC_LAST) begin
                        det_state    <= DET_HIT;
                        hit_pulse    <= 1'b1;
                        fail_latched <= 1'b1;
                     end
                  end else begin
                     consec_cnt <= '0;
                  end
               end
            end

            DET_HIT: begin
               if (home) begin
                  det_state    <= DET_IDLE;
                  fail_latched <= 1'b0;
               end
            end

            default: det_state <= DET_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_collision_detector.sv
// Randomized scoreboard bench: a frame-level model predicts each frame_tick's
// overlap snapshot, hit pulse and latch; a monitor compares on every tick.
module tb_collision_detector;
   import game_pkg::*;

   localparam int CNTW         = 4;
   localparam int HIT_THRESH   = 8;
   localparam int CONSEC       = 2;
   localparam int GRACE_FRAMES = 30;
   localparam int CNT_SAT      = (1 << CNTW) - 1;
   localparam int XL = 170, XH = 750, YL = 34, YH = 516, XE = 799, YE = 524;

   logic            CLK = 1'b0;
   logic            RESET;
   logic            pix_stb;
   logic [9:0]      hc, vc;
   logic [3:0]      state, player_pix, obstacle_pix;
   logic            hit_pulse, fail_latched, frame_tick;
   logic [CNTW-1:0] last_overlap;

   always #5 CLK = ~CLK;

   collision_detector #(
      .HIT_THRESH   (HIT_THRESH),
      .CONSEC       (CONSEC),
      .GRACE_FRAMES (GRACE_FRAMES),
      .CNTW         (CNTW)
   ) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .pix_stb      (pix_stb),
      .hc           (hc),
      .vc           (vc),
      .state        (state),
      .player_pix   (player_pix),
      .obstacle_pix (obstacle_pix),
      .hit_pulse    (hit_pulse),
      .fail_latched (fail_latched),
      .last_overlap (last_overlap),
      .frame_tick   (frame_tick)
   );

   typedef struct {
      int ovl;
      int hit;
      int latched;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Frame-level model: where the player is in the play session.
   int   m_frame_px;
   bit   m_in_play, m_armed, m_latched;
   int   m_grace, m_streak;
   int   m_state;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic bit m_running(input int s);
      return s >= 5 && s <= 10;
   endfunction

   function automatic bit m_home(input int s);
      return (s >= 0 && s <= 4) || (s >= 11 && s <= 13);
   endfunction

   task automatic model_reset();
      m_frame_px = 0;
      m_in_play  = 0;
      m_armed    = 0;
      m_latched  = 0;
      m_grace    = 0;
      m_streak   = 0;
   endtask

   task automatic model_state(input int s);
      m_state = s;
      if (m_home(s)) begin
         m_in_play = 0;
         m_armed   = 0;
         m_latched = 0;
         m_streak  = 0;
      end else if (m_running(s) && !m_in_play && !m_latched) begin
         m_in_play = 1;
         m_armed   = 0;
         m_grace   = 0;
      end
   endtask

   task automatic model_frame_end();
      exp_t e;
      int   c;
      int   hit;
      c   = (m_frame_px > CNT_SAT) ? CNT_SAT : m_frame_px;
      hit = 0;
      if (m_in_play && !m_armed) begin
         m_grace++;
         if (m_grace == GRACE_FRAMES) begin
            m_armed  = 1;
            m_streak = 0;
         end
      end else if (m_armed && m_running(m_state)) begin
         m_streak = (c >= HIT_THRESH) ? m_streak + 1 : 0;
         if (m_streak == CONSEC) begin
            hit       = 1;
            m_latched = 1;
            m_armed   = 0;
            m_in_play = 0;
         end
      end
      e.ovl     = c;
      e.hit     = hit;
      e.latched = m_latched;
      exp_q.push_back(e);
      m_frame_px = 0;
   endtask

   task automatic set_state(input int s);
      @(posedge CLK); #1;
      state = 4'(s);
      model_state(s);
   endtask

   // One strobed pixel, then one unstrobed cycle carrying overlapping noise.
   task automatic px(input int h, input int v, input int p, input int o);
      @(posedge CLK); #1;
      pix_stb      = 1'b1;
      hc           = 10'(h);
      vc           = 10'(v);
      player_pix   = 4'(p);
      obstacle_pix = 4'(o);
      if (h == XE && v == YE)
         model_frame_end();
      else if (h >= XL && h <= XH && v >= YL && v <= YH && p != 0 && o != 0)
         m_frame_px++;
      @(posedge CLK); #1;
      pix_stb      = 1'b0;
      hc           = 10'($urandom_range(XL, XH));
      vc           = 10'($urandom_range(YL, YH));
      player_pix   = 4'($urandom_range(1, 15));
      obstacle_pix = 4'($urandom_range(1, 15));
   endtask

   task automatic end_frame();
      px(XE, YE, $urandom_range(1, 15), $urandom_range(1, 15));
   endtask

   task automatic frame(input int n_hit, input int n_noise);
      for (int i = 0; i < n_noise; i++)
         px($urandom_range(0, 798), $urandom_range(0, 1023),
            $urandom_range(0, 15), $urandom_range(0, 15));
      for (int i = 0; i < n_hit; i++)
         px($urandom_range(XL, XH), $urandom_range(YL, YH),
            $urandom_range(1, 15), $urandom_range(1, 15));
      end_frame();
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (!RESET) begin
         if (hit_pulse)
            check("hit_pulse_with_frame_tick", int'(frame_tick), 1);
         if (frame_tick) begin
            if (exp_q.size() == 0) begin
               check("unexpected_frame_tick", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("last_overlap", int'(last_overlap), e.ovl);
               check("hit_pulse", int'(hit_pulse), e.hit);
               check("fail_latched", int'(fail_latched), e.latched);
            end
         end
      end
   end

   initial begin
      RESET        = 1'b1;
      pix_stb      = 1'b0;
      hc           = '0;
      vc           = '0;
      state        = TITLE;
      player_pix   = '0;
      obstacle_pix = '0;
      model_reset();
      m_state = 0;

      repeat (3) @(posedge CLK);
      #1;
      check("reset_hit_pulse", int'(hit_pulse), 0);
      check("reset_fail_latched", int'(fail_latched), 0);
      check("reset_last_overlap", int'(last_overlap), 0);
      check("reset_frame_tick", int'(frame_tick), 0);
      @(posedge CLK); #1;
      RESET = 1'b0;

      // Idle frames with only non-overlapping pixels.
      set_state(IDLE);
      for (int f = 0; f < 3; f++) begin
         px(300, 100, 0, 5);
         px(300, 100, 5, 0);
         end_frame();
      end

      // Grace period then a two-frame collision while moving between run states.
      for (int f = 0; f < GRACE_FRAMES + 2; f++) begin
         set_state($urandom_range(5, 10));
         frame(20, 2);
      end
      repeat (3) @(posedge CLK);
      #1;
      check("latched_after_first_hit", int'(fail_latched), 1);

      // Fail screens keep the latch without further pulses; menu clears it.
      set_state(FAIL1);
      for (int f = 0; f < 10; f++) frame(12, 2);
      set_state(IDLE);
      repeat (2) @(posedge CLK);
      #1;
      check("latch_cleared_on_home", int'(fail_latched), 0);

      // New session: window edges, saturation, then the 8,7,8,8 boundary pattern.
      set_state(RUN2);
      px(XL - 1, 200, 3, 3);
      px(XH + 1, 200, 3, 3);
      px(400, YL - 1, 3, 3);
      px(400, YH + 1, 3, 3);
      px(XL, YL, 2, 2);
      px(XH, YH, 2, 2);
      px(XL, YH, 2, 2);
      px(XH, YL, 2, 2);
      px(460, 275, 2, 2);
      end_frame();
      frame(40, 0);
      for (int f = 2; f < GRACE_FRAMES; f++) frame($urandom_range(0, 14), 3);
      frame(8, 0);
      frame(7, 0);
      frame(8, 0);
      frame(8, 0);

      // Consecutive count is frozen, not cleared, during a fail screen.
      set_state(TITLE);
      set_state(RUN1);
      for (int f = 0; f < GRACE_FRAMES; f++) frame($urandom_range(0, 16), 2);
      frame(9, 0);
      set_state(FAIL2);
      frame(0, 0);
      set_state(JUMP1);
      frame(9, 0);

      // Reset in the middle of an armed frame.
      set_state(TITLE);
      set_state(RUN1);
      for (int f = 0; f < GRACE_FRAMES; f++) frame($urandom_range(0, 16), 2);
      frame(10, 0);
      px(400, 300, 1, 1);
      px(401, 300, 1, 1);
      @(posedge CLK); #2;
      RESET = 1'b1;
      #1;
      check("midreset_hit_pulse", int'(hit_pulse), 0);
      check("midreset_fail_latched", int'(fail_latched), 0);
      check("midreset_last_overlap", int'(last_overlap), 0);
      check("midreset_frame_tick", int'(frame_tick), 0);
      model_reset();
      @(posedge CLK); #1;
      RESET = 1'b0;
      model_state(int'(state));
      frame(20, 0);
      frame(20, 0);

      repeat (5) @(posedge CLK);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/collision_detector.md
Name: collision_detector

Overview:
- Downstream of the level/obstacle renderer. Watches, pixel by pixel, whether the player sprite and the obstacle layer are both drawn at the same screen position.
- Accumulates that overlap per video frame, debounces it across frames, and reports a latched collision to the game state machine, which then moves to FAIL1/FAIL2.
- Runs on CLK; pixel cadence comes from a one-cycle strobe synchronous to CLK.

Parameters:
- H_MIN, 170, first hc counted as playfield (inclusive)
- H_MAX, 750, last hc counted as playfield (inclusive)
- V_MIN, 34, first vc counted (inclusive)
- V_MAX, 516, last vc counted (inclusive)
- H_LAST, 799, last hc of a scanline; used for frame-end detection
- V_LAST, 524, last vc of a frame; used for frame-end detection
- HIT_THRESH, 8, overlapping pixels per frame that mark the frame as "colliding"
- CONSEC, 2, consecutive colliding frames required to declare a hit (>=1)
- GRACE_FRAMES, 30, frames ignored after the game enters a running state (>=1)
- CNTW, 12, overlap counter width

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- pix_stb  in  1  one-CLK pulse per pixel; hc/vc/pixel inputs valid when high
- hc  in  10  horizontal counter
- vc  in  10  vertical counter
- state  in  4  game FSM state (same encoding as game FSM)
- player_pix  in  4  player sprite pixel; 0 = transparent
- obstacle_pix  in  4  obstacle layer pixel; 0 = transparent
- hit_pulse  out  1  one-CLK pulse when a collision is declared
- fail_latched  out  1  high from a declared hit until the game returns to a non-play state
- last_overlap  out  CNTW  overlap count of the most recently completed frame
- frame_tick  out  1  one-CLK pulse at each frame end

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, all counters 0.
- running = state in {RUN1..DUCK2} (5..10). home = state in {TITLE..TITLE4, IDLE, CHARSEL0, CHARSEL1} (0..4, 11..13).
- Overlap: on pix_stb, if H_MIN<=hc<=H_MAX and V_MIN<=vc<=V_MAX and player_pix!=0 and obstacle_pix!=0, increment ovl_cnt. ovl_cnt saturates at 2^CNTW-1 and never wraps.
- Frame end occurs when pix_stb && hc==H_LAST && vc==V_LAST.
  - Next cycle: frame_tick=1, last_overlap<=ovl_cnt, and ovl_cnt<=0.
  - The frame-end pixel lies outside the window, so it never adds to the count.
  - ovl_cnt counts in every FSM state; last_overlap updates every frame.
- FSM, with all evaluation done at frame end:
  - IDLE: when running, go to GRACE and clear grace_cnt.
  - GRACE: at each frame end, grace_cnt++. When grace_cnt reaches GRACE_FRAMES, go to ARMED and clear consec_cnt. If home, go to IDLE.
  - ARMED: at each frame end, if ovl_cnt>=HIT_THRESH then consec_cnt++, else consec_cnt<=0.
    - When the incremented value equals CONSEC: go to HIT, hit_pulse=1 for exactly one cycle (same cycle as frame_tick), fail_latched<=1.
    - If home (checked every cycle), go to IDLE and clear consec_cnt.
    - Non-running, non-home states (FAIL1/FAIL2) freeze consec_cnt and do not evaluate.
  - HIT: fail_latched held at 1; no further hit_pulse. When home, go to IDLE and clear fail_latched the next cycle.
- Simultaneous events:
  - A home state at a frame-end cycle takes priority over hit evaluation, so no hit is declared.
  - A frame end in the same cycle that IDLE sees running still moves only to GRACE; that frame is not counted as grace.
- Reset mid-frame: asynchronous clear of everything; counting restarts at the next strobe, so the first frame after reset is partial.
- Widths: grace_cnt and consec_cnt use $clog2(param+1) bits; all comparisons are unsigned.

Decomposition:
- Shared package game_pkg:
  - game-state localparams (TITLE..FAIL2, 4-bit)
  - playfield bounds H_MIN/H_MAX/V_MIN/V_MAX and H_LAST/V_LAST
  - the running/home classification, as constant functions
- One natural sub-module: overlap_counter.
  - Does the window qualify, the saturating count, and the frame-end snapshot/clear.
  - Outputs frame_tick and the snapshot to the FSM.

Test Plan:
- Reset, then run 3 frames with no overlap -> all outputs 0 except frame_tick pulsing once per frame; last_overlap=0.
- state=RUN1, GRACE_FRAMES=30, 20 overlap px/frame for 30 frames -> no hit_pulse, state stays GRACE. Then 2 more frames of 20 px -> hit_pulse exactly once at the end of frame 32; fail_latched=1.
- ARMED, overlap pattern 8,7,8,8 px -> counts as colliding, clear, colliding, colliding -> hit_pulse at the end of frame 4 only. Verifies the >= boundary at 8 and the consec reset on 7.
- Overlap pixels at hc=169, hc=751, vc=33, vc=517 plus 5 pixels inside the window -> last_overlap=5.
- After HIT, hold state=FAIL1 for 10 frames -> fail_latched stays 1 with no further pulses. Then state=IDLE -> fail_latched=0 within 2 cycles; FSM back in IDLE.
- CNTW=4 with 40 overlap px in one frame -> last_overlap=15 (saturates, no wrap). RESET asserted mid-frame in ARMED -> all outputs 0 immediately, FSM = IDLE.
